// File: rtl/wgt_col_reader.sv
// rtl/wgt_col_reader.sv - reads img2col weight rows from the column buffer and streams them to the cube
module wgt_col_reader #(
    parameter int SIZE = 8
) (
    input  logic                clock,
    input  logic                rst,
    input  logic                rd_start,
    input  logic [2:0]          kernel_size,
    input  logic [3:0]          valid_num,
    output logic [SIZE*5-1:0]   wgt_rd_addr,
    output logic [SIZE-1:0]     wgt_rd_en,
    input  logic [SIZE*128-1:0] wgt_rd_data,
    output logic [SIZE*128-1:0] cube_data,
    output logic                cube_valid,
    input  logic                cube_ready,
    output logic                cube_last,
    output logic                rd_busy,
    output logic                rd_done,
    output logic                rd_err
);
    localparam int W = SIZE * 128;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_DRAIN = 3'd2,
        S_DONE  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    state_t          state_q;
    logic [4:0]      n_q;
    logic [4:0]      issue_cnt_q;
    logic [SIZE-1:0] mask_q;
    logic            rd_busy_q;
    logic            rd_done_q;
    logic            rd_err_q;
    logic            inflight_q;
    logic            inflight_last_q;
    logic [W-1:0]    fifo_data_q [2];
    logic [1:0]      fifo_last_q;
    logic            wr_ptr_q;
    logic            rd_ptr_q;
    logic [1:0]      count_q;

    logic            start_legal;
    logic [4:0]      start_k;
    logic [4:0]      start_n;
    logic [SIZE-1:0] start_mask;
    logic            pop;
    logic            push;
    logic            issue;
    logic            issue_last;
    logic [2:0]      occupancy;
    logic [W-1:0]    masked_data;

    // Decode a start request: legality, row count and active-lane mask (lanes past SIZE drop out, which clamps valid_num)
    always_comb begin
        start_k     = {2'b00, kernel_size};
        start_n     = start_k * start_k;
        start_legal = (kernel_size >= 3'd1) && (kernel_size <= 3'd5) && (valid_num != 4'd0);
        for (int i = 0; i < SIZE; i++) begin
            start_mask[i] = (i < int'(valid_num));
        end
    end

    // A new read is allowed only while buffered plus in-flight rows, after this cycle's pop, stay below two
    assign cube_valid = (count_q != 2'd0);
    assign pop        = cube_valid && cube_ready;
    assign push       = inflight_q;
    assign occupancy  = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign issue      = (state_q == S_RUN) && (occupancy < 3'd2);
    assign issue_last = issue && (issue_cnt_q == (n_q - 5'd1));

    // Buffer read port: one shared row address, enables only on active lanes
    always_comb begin
        wgt_rd_en = issue ? mask_q : '0;
        for (int i = 0; i < SIZE; i++) begin
            wgt_rd_addr[i*5 +: 5] = issue ? issue_cnt_q : 5'd0;
        end
    end

    // Inactive lanes are zeroed before they enter the FIFO
    always_comb begin
        for (int i = 0; i < SIZE; i++) begin
            masked_data[i*128 +: 128] = wgt_rd_data[i*128 +: 128] & {128{mask_q[i]}};
        end
    end

    assign cube_data = cube_valid ? fifo_data_q[rd_ptr_q] : '0;
    assign cube_last = cube_valid && fifo_last_q[rd_ptr_q];
    assign rd_busy   = rd_busy_q;
    assign rd_done   = rd_done_q;
    assign rd_err    = rd_err_q;

    // Job sequencing with registered status outputs
    always_ff @(posedge clock) begin
        if (rst) begin
            state_q     <= S_IDLE;
            n_q         <= 5'd0;
            mask_q      <= '0;
            issue_cnt_q <= 5'd0;
            rd_busy_q   <= 1'b0;
            rd_done_q   <= 1'b0;
            rd_err_q    <= 1'b0;
        end else begin
            rd_done_q <= 1'b0;
            rd_err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (rd_start) begin
                        if (start_legal) begin
                            state_q     <= S_RUN;
                            n_q         <= start_n;
                            mask_q      <= start_mask;
                            issue_cnt_q <= 5'd0;
                            rd_busy_q   <= 1'b1;
                        end else begin
                            state_q   <= S_ERR;
                            rd_done_q <= 1'b1;
                            rd_err_q  <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (issue) begin
                        issue_cnt_q <= issue_cnt_q + 5'd1;
                        if (issue_last) begin
                            state_q <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (pop && cube_last) begin
                        state_q   <= S_DONE;
                        rd_done_q <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q   <= S_IDLE;
                    rd_busy_q <= 1'b0;
                end
                S_ERR: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Track the read in flight and the FIFO pointers; a reset drops any returning row
    always_ff @(posedge clock) begin
        if (rst) begin
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            wr_ptr_q        <= 1'b0;
            rd_ptr_q        <= 1'b0;
            count_q         <= 2'd0;
            fifo_last_q     <= 2'b00;
        end else begin
            inflight_q      <= issue;
            inflight_last_q <= issue_last;
            if (push) begin
                fifo_last_q[wr_ptr_q] <= inflight_last_q;
                wr_ptr_q              <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    // FIFO row storage; contents are only observed through cube_valid so no reset is needed
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_data_q[wr_ptr_q] <= masked_data;
        end
    end

    fifo_no_overflow: assert property (@(posedge clock) disable iff (rst)
        !(push && !pop && (count_q == 2'd2)));

endmodule

// File: tb/tb_wgt_col_reader.sv
// tb/tb_wgt_col_reader.sv - randomized self-checking bench for wgt_col_reader
module tb_wgt_col_reader;
    localparam int SIZE = 8;
    localparam int W    = SIZE * 128;

    logic                clock = 1'b0;
    logic                rst = 1'b1;
    logic                rd_start = 1'b0;
    logic [2:0]          kernel_size = 3'd0;
    logic [3:0]          valid_num = 4'd0;
    logic [SIZE*5-1:0]   wgt_rd_addr;
    logic [SIZE-1:0]     wgt_rd_en;
    logic [W-1:0]        wgt_rd_data = '0;
    logic [W-1:0]        cube_data;
    logic                cube_valid;
    logic                cube_ready = 1'b0;
    logic                cube_last;
    logic                rd_busy;
    logic                rd_done;
    logic                rd_err;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    int              t0 = 0;
    bit              legal = 1'b0;
    bit              err_job = 1'b0;
    int              exp_n = 0;
    logic [SIZE-1:0] exp_mask = '0;
    int              salt = 0;
    int              issued = 0;
    int              popped = 0;
    int              last_pop_cyc = -1;
    int              first_en_rel = -1;
    int              first_valid_rel = -1;
    int              last_rel = -1;
    int              done_rel = -1;
    int              err_rel = -1;
    int              busy_fall_rel = -1;
    logic [SIZE-1:0] en_or = '0;
    logic [W-1:0]    data_or = '0;
    logic [31:0]     beat2_lane1 = '0;
    bit              prev_stall = 1'b0;
    logic [W-1:0]    prev_data = '0;
    logic            prev_last = 1'b0;
    bit              prev_busy = 1'b0;

    wgt_col_reader #(.SIZE(SIZE)) dut (
        .clock       (clock),
        .rst         (rst),
        .rd_start    (rd_start),
        .kernel_size (kernel_size),
        .valid_num   (valid_num),
        .wgt_rd_addr (wgt_rd_addr),
        .wgt_rd_en   (wgt_rd_en),
        .wgt_rd_data (wgt_rd_data),
        .cube_data   (cube_data),
        .cube_valid  (cube_valid),
        .cube_ready  (cube_ready),
        .cube_last   (cube_last),
        .rd_busy     (rd_busy),
        .rd_done     (rd_done),
        .rd_err      (rd_err)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [127:0] lane_val(int r, int i, int s);
        return {32'(s), 32'(s ^ (r * 7)), 32'(i), 32'(r * 16 + i)};
    endfunction

    function automatic logic [W-1:0] exp_row(int r, logic [SIZE-1:0] m, int s);
        logic [W-1:0] v;
        v = '0;
        for (int i = 0; i < SIZE; i++) begin
            if (m[i]) v[i*128 +: 128] = lane_val(r, i, s);
        end
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_data(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        int idx;
        checks++;
        if (act !== exp) begin
            failures++;
            idx = 0;
            for (int i = SIZE - 1; i >= 0; i--) begin
                if (act[i*128 +: 128] !== exp[i*128 +: 128]) idx = i;
            end
            $display("FAIL %s lane=%0d actual=%h required=%h (cycle %0d)", name, idx,
                     act[idx*128 +: 128], exp[idx*128 +: 128], cyc);
        end
    endtask

    // Column buffer: returns the addressed row one cycle after a read, garbage on unread lanes
    always @(posedge clock) begin
        for (int i = 0; i < SIZE; i++) begin
            wgt_rd_data[i*128 +: 128] <= wgt_rd_en[i] ? lane_val(int'(wgt_rd_addr[i*5 +: 5]), i, salt)
                                                      : {$urandom, $urandom, $urandom, $urandom};
        end
    end

    // Per-cycle comparison of the DUT against the job model
    always @(negedge clock) begin : monitor
        int rel;
        logic [SIZE*5-1:0] exp_addr;
        bit exp_done;
        bit exp_err;
        bit exp_busy;
        if (rst) begin
            prev_stall = 1'b0;
            prev_busy  = 1'b0;
        end else begin
            rel = cyc - t0;
            if (wgt_rd_en != '0) begin
                check("issue_allowed", (legal && issued < exp_n), 1);
                check("rd_en_mask", wgt_rd_en, exp_mask);
                for (int i = 0; i < SIZE; i++) exp_addr[i*5 +: 5] = 5'(issued);
                check("rd_addr", wgt_rd_addr, exp_addr);
                if (first_en_rel < 0) first_en_rel = rel;
                en_or = en_or | wgt_rd_en;
                issued++;
            end
            if (prev_stall) begin
                check("stall_valid", cube_valid, 1);
                check_data("stall_data", cube_data, prev_data);
                check("stall_last", cube_last, prev_last);
            end
            if (cube_valid) begin
                check("beat_expected", (legal && popped < exp_n), 1);
                check_data("cube_data", cube_data, exp_row(popped, exp_mask, salt));
                check("cube_last", cube_last, (popped == exp_n - 1));
                if (first_valid_rel < 0) first_valid_rel = rel;
                data_or = data_or | cube_data;
                if (popped == 2) beat2_lane1 = cube_data[128 +: 32];
                if (cube_last) last_rel = rel;
                if (cube_ready) begin
                    if (popped == exp_n - 1) last_pop_cyc = cyc;
                    popped++;
                end
            end
            if (legal) check("occupancy", ((issued - popped) <= 2), 1);
            exp_done = legal ? (last_pop_cyc >= 0 && cyc == last_pop_cyc + 1) : (err_job && rel == 1);
            exp_err  = !legal && err_job && rel == 1;
            exp_busy = legal && rel >= 1 && (last_pop_cyc < 0 || cyc <= last_pop_cyc + 1);
            check("rd_done", rd_done, exp_done);
            check("rd_err", rd_err, exp_err);
            check("rd_busy", rd_busy, exp_busy);
            if (rd_done) done_rel = rel;
            if (rd_err) err_rel = rel;
            if (prev_busy && !rd_busy && busy_fall_rel < 0) busy_fall_rel = rel;
            prev_busy  = rd_busy;
            prev_stall = cube_valid && !cube_ready;
            prev_data  = cube_data;
            prev_last  = cube_last;
        end
    end

    task automatic check_reset_values();
        check("rst_rd_en", wgt_rd_en, 0);
        check("rst_rd_addr", wgt_rd_addr, 0);
        check("rst_cube_valid", cube_valid, 0);
        check("rst_cube_last", cube_last, 0);
        check("rst_cube_data_zero", (cube_data == '0), 1);
        check("rst_busy", rd_busy, 0);
        check("rst_done", rd_done, 0);
        check("rst_err", rd_err, 0);
    endtask

    task automatic start(input int k, input int vn, input int s);
        @(posedge clock);
        #2;
        kernel_size     = 3'(k);
        valid_num       = 4'(vn);
        rd_start        = 1'b1;
        cube_ready      = 1'b1;
        t0              = cyc;
        first_en_rel    = -1;
        first_valid_rel = -1;
        last_rel        = -1;
        done_rel        = -1;
        err_rel         = -1;
        busy_fall_rel   = -1;
        en_or           = '0;
        data_or         = '0;
        beat2_lane1     = '0;
        issued          = 0;
        popped          = 0;
        last_pop_cyc    = -1;
        legal           = (k >= 1 && k <= 5 && vn != 0);
        err_job         = !legal;
        if (legal) begin
            exp_n = k * k;
            for (int i = 0; i < SIZE; i++) exp_mask[i] = (i < vn);
            salt = s;
        end
    endtask

    // mode: 0 ready high, 1 ready pattern 1,0,0,1,0,1, 2 random ready
    // extra: 1 re-pulse start mid-job, 2 start in the rd_done cycle, 3 reset after beat 5
    task automatic run_job(input int k, input int vn, input int s, input int mode, input int extra);
        bit fin;
        int rel;
        bit pat [6];
        pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1; pat[4] = 0; pat[5] = 1;
        start(k, vn, s);
        if (!legal) begin
            repeat (4) begin
                @(posedge clock);
                #2;
                rd_start = 1'b0;
            end
            check("err_rel", err_rel, 1);
            check("err_no_reads", en_or, 0);
            return;
        end
        fin = 1'b0;
        for (int c = 0; c < 400 && !fin; c++) begin
            @(posedge clock);
            #2;
            rd_start = 1'b0;
            rel = cyc - t0;
            case (mode)
                0:       cube_ready = 1'b1;
                1:       cube_ready = pat[rel % 6];
                default: cube_ready = ($urandom_range(0, 2) != 0);
            endcase
            if (extra == 1 && rel == 4) begin
                rd_start    = 1'b1;
                kernel_size = 3'd1;
                valid_num   = 4'd1;
            end
            if (extra == 3 && popped >= 5) begin
                rst     = 1'b1;
                legal   = 1'b0;
                err_job = 1'b0;
                @(posedge clock);
                #2;
                check_reset_values();
                rst = 1'b0;
                return;
            end
            if (rd_done) begin
                if (extra == 2) begin
                    rd_start    = 1'b1;
                    kernel_size = 3'd2;
                    valid_num   = 4'd8;
                end
                fin = 1'b1;
            end
        end
        check("job_done_in_budget", fin, 1);
        repeat (3) begin
            @(posedge clock);
            #2;
            rd_start   = 1'b0;
            cube_ready = 1'b1;
        end
        check("beats", popped, exp_n);
        check("reads", issued, exp_n);
        if (mode == 0) check("done_latency", done_rel, exp_n + 3);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clock);
        #2;
        check_reset_values();
        rst = 1'b0;

        run_job(3, 8, 0, 0, 0);
        check("t1_first_en", first_en_rel, 1);
        check("t1_first_valid", first_valid_rel, 3);
        check("t1_last", last_rel, 11);
        check("t1_done", done_rel, 12);
        check("t1_busy_fall", busy_fall_rel, 13);
        check("t1_beat2_lane1", beat2_lane1, 33);

        run_job(5, 3, int'($urandom), 0, 0);
        check("t2_en_lanes", en_or, 8'h07);
        check("t2_upper_lanes_zero", (data_or[W-1:3*128] == '0), 1);
        check("t2_beats", popped, 25);
        check("t2_last", last_rel, 27);

        run_job(2, 8, int'($urandom), 1, 0);
        check("t3_beats", popped, 4);

        run_job(0, 8, 0, 0, 0);
        run_job(6, 8, 0, 0, 0);
        run_job(3, 0, 0, 0, 0);

        run_job(4, 8, int'($urandom), 0, 3);
        run_job(1, 8, int'($urandom), 0, 0);
        check("t5_beats", popped, 1);
        check("t5_last", last_rel, 3);
        check("t5_done", done_rel, 4);

        run_job(3, 12, int'($urandom), 0, 1);
        check("t6_beats", popped, 9);
        check("t6_en_lanes", en_or, 8'hff);

        run_job(2, 5, int'($urandom), 0, 2);

        for (int j = 0; j < 12; j++) begin
            run_job(int'($urandom_range(0, 6)), int'($urandom_range(0, 15)), int'($urandom), 2, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
